// File: rtl/axi4lite_slave_regs.sv
// rtl/axi4lite_slave_regs.sv - AXI4-Lite register-file slave; optional macro AXI_SLVERR_EN turns out-of-range responses into SLVERR
`default_nettype none

module axi4lite_slave_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    // write address channel
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    // write data channel
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                      WVALID,
    output logic                      WREADY,
    // write response channel
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    // read address channel
    input  logic [ADDR_WIDTH-1:0]     ARADDR,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    // read data channel
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    // comparison width wide enough to hold NUM_REGS (up to 256) without truncation
    localparam int CMP_W    = (IDX_W > 10) ? IDX_W : 10;
    localparam int REG_IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_SLVERR_EN
    localparam logic [1:0] RESP_OOR  = 2'b10;
`else
    localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

    // write-path states
    localparam logic [1:0] W_IDLE    = 2'd0;
    localparam logic [1:0] W_WAIT_AW = 2'd1;
    localparam logic [1:0] W_WAIT_W  = 2'd2;
    localparam logic [1:0] W_RESP    = 2'd3;

    // read-path states
    localparam logic [0:0] R_IDLE    = 1'b0;
    localparam logic [0:0] R_DATA    = 1'b1;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic [1:0]            r_wstate;
    logic [1:0]            w_wstate_nxt;
    logic [0:0]            r_rstate;
    logic                  r_ready_en;

    logic [IDX_W-1:0]      r_aw_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic [1:0]            r_bresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_wr_fire;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [STRB_W-1:0]     w_wr_strb;
    logic                  w_wr_in_range;
    logic [IDX_W-1:0]      w_ar_idx;
    logic                  w_ar_in_range;
    logic                  w_unused_lsbs;

    // byte-offset bits never select anything
    assign w_unused_lsbs = ^{AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

    // channel handshake outputs; readiness is held off until the first edge after reset
    assign AWREADY = r_ready_en & ((r_wstate == W_IDLE) | (r_wstate == W_WAIT_AW));
    assign WREADY  = r_ready_en & ((r_wstate == W_IDLE) | (r_wstate == W_WAIT_W));
    assign BVALID  = (r_wstate == W_RESP);
    assign BRESP   = r_bresp;
    assign ARREADY = r_ready_en & (r_rstate == R_IDLE);
    assign RVALID  = (r_rstate == R_DATA);
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;

    assign w_aw_hs = AWVALID & AWREADY;
    assign w_w_hs  = WVALID & WREADY;
    assign w_b_hs  = BVALID & BREADY;
    assign w_ar_hs = ARVALID & ARREADY;
    assign w_r_hs  = RVALID & RREADY;

    // a handshake happening this cycle supplies its payload directly, otherwise use the latched copy
    assign w_wr_idx  = w_aw_hs ? AWADDR[ADDR_WIDTH-1:ADDR_LSB] : r_aw_idx;
    assign w_wr_data = w_w_hs  ? WDATA : r_wdata;
    assign w_wr_strb = w_w_hs  ? WSTRB : r_wstrb;
    assign w_ar_idx  = ARADDR[ADDR_WIDTH-1:ADDR_LSB];

    assign w_wr_in_range = (CMP_W'(w_wr_idx) < CMP_W'(NUM_REGS));
    assign w_ar_in_range = (CMP_W'(w_ar_idx) < CMP_W'(NUM_REGS));

    // the write commits on exactly the edge that enters W_RESP
    assign w_wr_fire = (r_wstate != W_RESP) && (w_wstate_nxt == W_RESP);

    // write FSM next-state: collect AW and W in either order, then respond
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_wstate_nxt = W_RESP;
                end else if (w_aw_hs) begin
                    w_wstate_nxt = W_WAIT_W;
                end else if (w_w_hs) begin
                    w_wstate_nxt = W_WAIT_AW;
                end
            end
            W_WAIT_W: begin
                if (w_w_hs) begin
                    w_wstate_nxt = W_RESP;
                end
            end
            W_WAIT_AW: begin
                if (w_aw_hs) begin
                    w_wstate_nxt = W_RESP;
                end
            end
            default: begin
                if (w_b_hs) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
        endcase
    end

    // ready enable: low in reset, high from the first rising edge afterwards
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    // write FSM state, payload latches and response code
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate <= W_IDLE;
            r_aw_idx <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= RESP_OKAY;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (w_aw_hs) begin
                r_aw_idx <= AWADDR[ADDR_WIDTH-1:ADDR_LSB];
            end
            if (w_w_hs) begin
                r_wdata <= WDATA;
                r_wstrb <= WSTRB;
            end
            if (w_wr_fire) begin
                r_bresp <= w_wr_in_range ? RESP_OKAY : RESP_OOR;
            end
        end
    end

    // register file: byte-strobed update on write commit, out-of-range writes dropped
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_fire && w_wr_in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_wr_strb[b]) begin
                    r_regs[REG_IW'(w_wr_idx)][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                end
            end
        end
    end

    // read FSM: capture data on AR handshake (sees pre-write contents), hold until RREADY
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate <= R_DATA;
                        if (w_ar_in_range) begin
                            r_rdata <= r_regs[REG_IW'(w_ar_idx)];
                            r_rresp <= RESP_OKAY;
                        end else begin
                            r_rdata <= '0;
                            r_rresp <= RESP_OOR;
                        end
                    end
                end
                default: begin
                    if (w_r_hs) begin
                        r_rstate <= R_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire
